// File: rtl/demux_fifo.sv
// demux_fifo: 1-to-2 word demultiplexer that steers each accepted word into one of two output FIFOs.
// Define DEMUX_CNT_EN to enable the saturating per-port delivered-word counters Cnt1/Cnt2.
module demux_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] DI,
   input  logic             SelData,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] DO1,
   output logic             OutValid1,
   input  logic             OutReady1,
   output logic [WIDTH-1:0] DO2,
   output logic             OutValid2,
   input  logic             OutReady2,
   output logic [CNT_W-1:0] Cnt1,
   output logic [CNT_W-1:0] Cnt2
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [1:0]            full;
   logic [1:0]            valid;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0]            rdy;
   logic [1:0][WIDTH-1:0] head;
   logic [1:0][CNT_W-1:0] cnt;
   // Acceptance looks only at the selected FIFO's registered fullness, never at consumer ready.
   assign InReady = ~full[SelData];
   assign rdy     = {OutReady2, OutReady1};
   assign push    = {2{InValid & InReady}} & {SelData, ~SelData};
   assign pop     = valid & rdy;
   generate
      for (genvar p = 0; p < 2; p++) begin : g_port
         logic [WIDTH-1:0] mem_q [DEPTH];
         logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
         logic [CW-1:0]    cnt_q, cnt_d;
         always_comb begin
            wr_d  = push[p] ? wr_q + PW'(1) : wr_q;
            rd_d  = pop[p] ? rd_q + PW'(1) : rd_q;
            cnt_d = cnt_q + CW'(push[p]) - CW'(pop[p]);
         end
         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               wr_q  <= '0;
               rd_q  <= '0;
               cnt_q <= '0;
            end else begin
               wr_q  <= wr_d;
               rd_q  <= rd_d;
               cnt_q <= cnt_d;
            end
         end
         always_ff @(posedge Clk) begin
            if (push[p]) mem_q[wr_q] <= DI;
         end
         assign full[p]  = cnt_q == CW'(DEPTH);
         assign valid[p] = cnt_q != '0;
         assign head[p]  = valid[p] ? mem_q[rd_q] : '0;
`ifdef DEMUX_CNT_EN
         logic [CNT_W-1:0] tx_q, tx_d;
         assign tx_d = (pop[p] && !(&tx_q)) ? tx_q + CNT_W'(1) : tx_q;
         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) tx_q <= '0;
            else tx_q <= tx_d;
         end
         assign cnt[p] = tx_q;
`else
         assign cnt[p] = '0;
`endif
      end
   endgenerate
   assign DO1       = head[0];
   assign DO2       = head[1];
   assign OutValid1 = valid[0];
   assign OutValid2 = valid[1];
   assign Cnt1      = cnt[0];
   assign Cnt2      = cnt[1];
endmodule

// File: tb/tb_demux_fifo.sv
// tb_demux_fifo: directed and random stimulus for demux_fifo against a queue-based reference model.
module tb_demux_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 4;
   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic [WIDTH-1:0] DI = '0;
   logic             SelData = 1'b0;
   logic             InValid = 1'b0;
   logic             InReady;
   logic [WIDTH-1:0] DO1, DO2;
   logic             OutValid1, OutValid2;
   logic             OutReady1 = 1'b0;
   logic             OutReady2 = 1'b0;
   logic [CNT_W-1:0] Cnt1, Cnt2;
   int               errors = 0;
   int               checks = 0;
   logic [31:0]      q1[$];
   logic [31:0]      q2[$];
   int               m_cnt1 = 0;
   int               m_cnt2 = 0;
   localparam int    CNT_MAX = (1 << CNT_W) - 1;

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .DI(DI), .SelData(SelData), .InValid(InValid),
      .InReady(InReady), .DO1(DO1), .OutValid1(OutValid1), .OutReady1(OutReady1),
      .DO2(DO2), .OutValid2(OutValid2), .OutReady2(OutReady2), .Cnt1(Cnt1), .Cnt2(Cnt2)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int exp_cnt(input int n);
`ifdef DEMUX_CNT_EN
      return n > CNT_MAX ? CNT_MAX : n;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      q1.delete();
      q2.delete();
      m_cnt1 = 0;
      m_cnt2 = 0;
   endtask

   // One cycle: drive, check every output against the model at negedge, then commit the edge to the model.
   task automatic step(input logic v, input logic s, input logic [31:0] d, input logic r1, input logic r2);
      logic e_rdy, do_push, p1, p2;
      InValid = v; SelData = s; DI = d; OutReady1 = r1; OutReady2 = r2;
      @(negedge Clk);
      e_rdy = s ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
      chk("InReady", 32'(InReady), 32'(e_rdy));
      chk("OutValid1", 32'(OutValid1), 32'(q1.size() != 0));
      chk("DO1", DO1, q1.size() != 0 ? q1[0] : 32'h0);
      chk("OutValid2", 32'(OutValid2), 32'(q2.size() != 0));
      chk("DO2", DO2, q2.size() != 0 ? q2[0] : 32'h0);
      chk("Cnt1", 32'(Cnt1), 32'(exp_cnt(m_cnt1)));
      chk("Cnt2", 32'(Cnt2), 32'(exp_cnt(m_cnt2)));
      do_push = v && e_rdy;
      p1 = r1 && q1.size() != 0;
      p2 = r2 && q2.size() != 0;
      @(posedge Clk);
      if (p1) begin void'(q1.pop_front()); m_cnt1++; end
      if (p2) begin void'(q2.pop_front()); m_cnt2++; end
      if (do_push) begin
         if (s) q2.push_back(d);
         else q1.push_back(d);
      end
      #1;
   endtask

   initial begin
      @(negedge Clk);
      chk("rst_OutValid1", 32'(OutValid1), 32'h0);
      chk("rst_OutValid2", 32'(OutValid2), 32'h0);
      chk("rst_DO1", DO1, 32'h0);
      chk("rst_DO2", DO2, 32'h0);
      chk("rst_Cnt1", 32'(Cnt1), 32'h0);
      Rst_n = 1'b1;
      step(0, 0, 32'h0, 0, 0);
      // single word through port 1, one cycle latency, then drained
      step(1, 0, 32'hA5A5_0001, 0, 0);
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 0, 0);
      // fill port 2, port 1 stays accessible, drain in order
      step(1, 1, 32'h11, 0, 0);
      step(1, 1, 32'h22, 0, 0);
      step(1, 1, 32'h99, 0, 0);
      chk("full_port2_InReady", 32'(InReady), 32'h0);
      step(1, 1, 32'h98, 0, 1);
      step(1, 0, 32'h33, 0, 0);
      step(0, 0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 0, 0);
      // port 1 holds 0x33: simultaneous push 0x44 and pop keeps count at 1
      step(1, 0, 32'h44, 1, 0);
      chk("pushpop_q1_size", 32'(q1.size()), 32'd1);
      step(0, 0, 32'h0, 0, 0);
      chk("pushpop_DO1", DO1, 32'h44);
      // fill both then reset asynchronously mid-stream
      step(1, 0, 32'h55, 0, 0);
      step(1, 1, 32'h66, 0, 0);
      step(1, 1, 32'h77, 0, 0);
      #2 Rst_n = 1'b0;
      #1;
      chk("arst_OutValid1", 32'(OutValid1), 32'h0);
      chk("arst_OutValid2", 32'(OutValid2), 32'h0);
      chk("arst_DO1", DO1, 32'h0);
      chk("arst_InReady", 32'(InReady), 32'h1);
      InValid = 1'b0; OutReady1 = 1'b0; OutReady2 = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      model_reset();
      @(posedge Clk);
      #1;
      step(0, 1, 32'h0, 1, 1);
      // 17 words delivered on port 1 saturate Cnt1
      for (int i = 0; i < 17; i++) step(1, 0, 32'h100 + i, 1, 0);
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 0, 0);
`ifdef DEMUX_CNT_EN
      chk("sat_Cnt1", 32'(Cnt1), 32'hF);
`else
      chk("sat_Cnt1", 32'(Cnt1), 32'h0);
`endif
      chk("sat_Cnt2", 32'(Cnt2), 32'h0);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
